// File: rtl/ins_cache_r32i.sv
// Direct-mapped read-only instruction cache. It refills one line word by word over a req/valid port.
// Define ICACHE_STATS_EN to add the saturating HitCount/MissCount outputs.
module ins_cache_r32i #(
    parameter int unsigned dataW = 32,
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    input  logic             Flush,
    output logic [dataW-1:0] Instruction,
    output logic             InsCacheStall,
    output logic             MemReq,
    output logic [dataW-1:0] MemAddr,
    input  logic             MemValid,
`ifdef ICACHE_STATS_EN
    input  logic [dataW-1:0] MemData,
    output logic [31:0]      HitCount,
    output logic [31:0]      MissCount
`else
    input  logic [dataW-1:0] MemData
`endif
);
    localparam int unsigned OffW = $clog2(WORDS);
    localparam int unsigned IdxW = $clog2(LINES);
    localparam int unsigned TagW = dataW - IdxW - OffW - 2;
    localparam logic [dataW-1:0] Nop = dataW'(32'h0000_0013);

    typedef enum logic [1:0] {StIdle, StRefill, StFillDone} state_e;

    state_e           state_q;
    logic [LINES-1:0] valid_q;
    logic [TagW-1:0]  tag_q  [LINES];
    logic [dataW-1:0] data_q [LINES][WORDS];
    logic [TagW-1:0]  rf_tag_q;
    logic [IdxW-1:0]  rf_idx_q;
    logic [OffW-1:0]  cnt_q;
    logic             mem_req_q;
    logic [dataW-1:0] mem_addr_q;
    logic             flush_pend_q;

    logic [OffW-1:0]  off;
    logic [IdxW-1:0]  idx;
    logic [TagW-1:0]  tag;
    logic             hit;
    logic             start_refill;
    logic             last_beat;
    logic             unused_addr;

    assign off         = ProgAddr[OffW+1:2];
    assign idx         = ProgAddr[IdxW+OffW+1:OffW+2];
    assign tag         = ProgAddr[dataW-1:IdxW+OffW+2];
    assign unused_addr = ^ProgAddr[1:0];

    always_comb begin
        hit           = (state_q == StIdle) && valid_q[idx] && (tag_q[idx] == tag);
        start_refill  = (state_q == StIdle) && !hit && !Flush;
        last_beat     = (state_q == StRefill) && MemValid && (cnt_q == OffW'(WORDS - 1));
        Instruction   = hit ? data_q[idx][off] : Nop;
        InsCacheStall = !hit;
    end

    assign MemReq  = mem_req_q;
    assign MemAddr = mem_addr_q;

    // Data and tag arrays carry no reset; valid_q alone decides whether they mean anything.
    always_ff @(posedge clock) begin
        if (reset && state_q == StRefill && MemValid) begin
            data_q[rf_idx_q][cnt_q] <= MemData;
        end
        if (reset && last_beat) begin
            tag_q[rf_idx_q] <= rf_tag_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            rf_tag_q     <= '0;
            rf_idx_q     <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Flush) begin
                        valid_q <= '0;
                    end else if (start_refill) begin
                        rf_tag_q   <= tag;
                        rf_idx_q   <= idx;
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {tag, idx, {OffW{1'b0}}, 2'b00};
                        state_q    <= StRefill;
                    end
                end
                StRefill: begin
                    if (Flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (last_beat) begin
                        mem_req_q          <= 1'b0;
                        valid_q[rf_idx_q] <= 1'b1;
                        state_q            <= StFillDone;
                    end else if (MemValid) begin
                        cnt_q      <= cnt_q + 1'b1;
                        mem_addr_q <= mem_addr_q + dataW'(4);
                    end
                end
                StFillDone: begin
                    // A flush seen during the refill also drops the line just filled.
                    if (Flush || flush_pend_q) begin
                        valid_q <= '0;
                    end
                    flush_pend_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (start_refill && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ins_cache_r32i.sv
// Self-checking bench for ins_cache_r32i: line-level cache model plus a bench-side memory
// responder with a programmable beat gap.
module tb_ins_cache_r32i;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int LB    = 4;  // byte-address bits covered by one line
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ProgAddr = '0;
    logic        Flush = 1'b0;
    logic [31:0] Instruction;
    logic        InsCacheStall;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemValid = 1'b0;
    logic [31:0] MemData = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] HitCount;
    logic [31:0] MissCount;
`endif

    always #5 clock = ~clock;

    ins_cache_r32i #(.dataW(32), .LINES(LINES), .WORDS(WORDS)) dut (
        .clock        (clock),
        .reset        (reset),
        .ProgAddr     (ProgAddr),
        .Flush        (Flush),
        .Instruction  (Instruction),
        .InsCacheStall(InsCacheStall),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemValid     (MemValid),
`ifdef ICACHE_STATS_EN
        .MemData      (MemData),
        .HitCount     (HitCount),
        .MissCount    (MissCount)
`else
        .MemData      (MemData)
`endif
    );

    logic [31:0] mem [1024];
    bit          mvalid [LINES];
    logic [31:0] mline  [LINES];
    logic [31:0] beats [$];
    int          errors = 0;
    int          checks = 0;
    int          gap = 0;
    int          wait_cnt = 0;
    int          hits_m = 0;
    int          misses_m = 0;
    logic        rst_drv = 1'b0;
    logic        s_stall;
    logic [31:0] s_ins;

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, act as memory, sample outputs 1ns later.
    task automatic tick(input logic [31:0] a, input logic fl);
        @(negedge clock);
        reset    = rst_drv;
        ProgAddr = a;
        Flush    = fl;
        if (MemReq === 1'b1 && wait_cnt == gap) begin
            MemValid = 1'b1;
            MemData  = mem[MemAddr[11:2]];
            beats.push_back(MemAddr);
            wait_cnt = 0;
        end else if (MemReq === 1'b1) begin
            MemValid = 1'b0;
            MemData  = $urandom;
            wait_cnt++;
        end else begin
            MemValid = ($urandom_range(0, 3) == 0);
            MemData  = $urandom;
            wait_cnt = 0;
        end
        #1;
        s_stall = InsCacheStall;
        s_ins   = Instruction;
    endtask

    // Fetch one address until it is delivered; checks stall length, data and refill addresses.
    task automatic fetch(input logic [31:0] a, input int g);
        logic [31:0] line;
        int          idx;
        bit          hm;
        int          n;
        int          exp_n;
        line  = a >> LB;
        idx   = int'(line % LINES);
        hm    = mvalid[idx] && (mline[idx] == line);
        exp_n = hm ? 0 : WORDS * (g + 1) + 2;
        gap   = g;
        beats.delete();
        n = 0;
        tick(a, 1'b0);
        while (s_stall !== 1'b0 && n < 200) begin
            checks++;
            if (s_ins !== NOP) begin
                errors++;
                $display("FAIL stall_nop addr=%h got=%h want=%h", a, s_ins, NOP);
            end
            n++;
            tick(a, 1'b0);
        end
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL stall_len addr=%h got=%0d want=%0d", a, n, exp_n);
        end
        checks++;
        if (s_ins !== mem[a[11:2]]) begin
            errors++;
            $display("FAIL hit_data addr=%h got=%h want=%h", a, s_ins, mem[a[11:2]]);
        end
        checks++;
        if (MemReq !== 1'b0) begin
            errors++;
            $display("FAIL hit_memreq addr=%h got=%b want=0", a, MemReq);
        end
        if (!hm) begin
            checks++;
            if (beats.size() != WORDS) begin
                errors++;
                $display("FAIL beat_count addr=%h got=%0d want=%0d", a, beats.size(), WORDS);
            end else begin
                for (int k = 0; k < WORDS; k++) begin
                    checks++;
                    if (beats[k] !== (line << LB) + 32'(4 * k)) begin
                        errors++;
                        $display("FAIL beat_addr k=%0d got=%h want=%h", k, beats[k],
                                 (line << LB) + 32'(4 * k));
                    end
                end
            end
            misses_m++;
        end
        hits_m++;
        mvalid[idx] = 1'b1;
        mline[idx]  = line;
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        tick(32'h0, 1'b0);
        tick(32'h0, 1'b0);
        rst_drv = 1'b1;
        model_clear();
        hits_m   = 0;
        misses_m = 0;
    endtask

    task automatic test_reset();
        rst_drv = 1'b0;
        tick(32'h0, 1'b0);
        tick(32'h0, 1'b0);
        checks++;
        if (s_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b want=1", s_stall); end
        checks++;
        if (s_ins !== NOP) begin errors++; $display("FAIL rst_ins got=%h want=%h", s_ins, NOP); end
        checks++;
        if (MemReq !== 1'b0) begin errors++; $display("FAIL rst_memreq got=%b want=0", MemReq); end
        checks++;
        if (MemAddr !== 32'h0) begin errors++; $display("FAIL rst_memaddr got=%h want=0", MemAddr); end
`ifdef ICACHE_STATS_EN
        checks++;
        if (HitCount !== 0 || MissCount !== 0) begin
            errors++;
            $display("FAIL rst_stats got=%0d/%0d want=0/0", HitCount, MissCount);
        end
`endif
        rst_drv = 1'b1;
        model_clear();
    endtask

    task automatic test_cold_and_seq();
        fetch(32'h0, 0);
        fetch(32'h4, 0);
        fetch(32'h8, 0);
        fetch(32'hC, 0);
    endtask

    task automatic test_conflict();
        fetch(32'h100, 0);
        fetch(32'h0, 0);
        fetch(32'hFC, 1);
        fetch(32'h100, 0);
    endtask

    task automatic test_slow_mem();
        fetch(32'h208, 2);
        fetch(32'h204, 0);
    endtask

    task automatic test_flush_hit();
        tick(32'h204, 1'b1);
        checks++;
        if (s_stall !== 1'b0 || s_ins !== mem[32'h204 >> 2]) begin
            errors++;
            $display("FAIL flush_hit got=%b/%h want=0/%h", s_stall, s_ins, mem[32'h204 >> 2]);
        end
        model_clear();
        fetch(32'h204, 0);
    endtask

    task automatic test_flush_refill();
        gap = 0;
        beats.delete();
        for (int c = 0; c < 6; c++) begin
            tick(32'h300, c == 2);
            checks++;
            if (s_stall !== 1'b1) begin
                errors++;
                $display("FAIL flush_rf_stall cyc=%0d got=%b want=1", c, s_stall);
            end
        end
        checks++;
        if (beats.size() != WORDS) begin
            errors++;
            $display("FAIL flush_rf_beats got=%0d want=%0d", beats.size(), WORDS);
        end
        model_clear();
        fetch(32'h300, 0);
    endtask

    task automatic test_reset_mid();
        gap = 0;
        tick(32'h400, 1'b0);
        tick(32'h400, 1'b0);
        tick(32'h400, 1'b0);
        rst_drv = 1'b0;
        tick(32'h400, 1'b0);
        @(posedge clock);
        #1;
        checks++;
        if (MemReq !== 1'b0) begin errors++; $display("FAIL rstmid_memreq got=%b want=0", MemReq); end
        checks++;
        if (InsCacheStall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stall got=%b want=1", InsCacheStall);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (HitCount !== 0 || MissCount !== 0) begin
            errors++;
            $display("FAIL rstmid_stats got=%0d/%0d want=0/0", HitCount, MissCount);
        end
`endif
        rst_drv = 1'b1;
        model_clear();
        fetch(32'h0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            fetch(32'($urandom_range(0, 127)) << 2, int'($urandom_range(0, 2)));
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (HitCount !== 32'(hits_m) || MissCount !== 32'(misses_m)) begin
            errors++;
            $display("FAIL stats got=%0d/%0d want=%0d/%0d", HitCount, MissCount, hits_m, misses_m);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'hA0;
        mem[1] = 32'hA1;
        mem[2] = 32'hA2;
        mem[3] = 32'hA3;
        test_reset();
        test_cold_and_seq();
        test_conflict();
        test_slow_mem();
        test_flush_hit();
        test_flush_refill();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/ins_cache_r32i.md
Name: ins_cache_r32i

Overview:
- Direct-mapped, read-only instruction cache that sits directly downstream of the PC.
- Consumes ProgAddr every cycle. On a hit, returns the 32-bit instruction in the same cycle.
- On a miss, drives InsCacheStall back to the PC and refills the whole line from instruction memory over a simple word-by-word request/valid handshake.
- A Flush input invalidates all lines (FENCE.I support).

Parameters:
- dataW, 32, address/data width; only 32 is supported.
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- ProgAddr  input  dataW  fetch address from the PC; bits [1:0] ignored.
- Flush  input  1  one-cycle request to invalidate every line.
- Instruction  output  dataW  instruction at ProgAddr; valid when InsCacheStall=0.
- InsCacheStall  output  1  high while the instruction is not available; PC must hold.
- MemReq  output  1  word read request to instruction memory.
- MemAddr  output  dataW  word-aligned read address; bits [1:0]=0.
- MemValid  input  1  memory returns one word this cycle for the outstanding request.
- MemData  input  dataW  returned word, qualified by MemValid.

Behaviour:
- Address split:
  - offset = ProgAddr[log2(WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage per line: valid bit, tag, WORDS data words. Data arrays need no reset.
- Reset (reset=0 at a clock edge):
  - all valid bits cleared, FSM to IDLE, MemReq=0, MemAddr=0, refill word counter=0, pending flush cleared.
  - Consequently InsCacheStall=1 and Instruction=32'h00000013 (NOP) until the first refill completes.
- Hit (combinational): IDLE and valid[index] and tag match.
  - Instruction = data[index][offset].
  - InsCacheStall = 0.
- Otherwise InsCacheStall=1 and Instruction=32'h00000013.
- FSM states: IDLE, REFILL, FILL_DONE.
- IDLE:
  - Miss and no Flush: latch tag/index into a refill register, word counter=0, MemReq=1, MemAddr={tag,index,0,2'b00}; go to REFILL.
  - Flush in IDLE: clear all valid bits this edge; no refill starts that cycle.
  - Flush is honoured even on a hit cycle. InsCacheStall stays as computed for that cycle; the next cycle misses.
- REFILL:
  - MemReq held at 1; MemAddr held stable until MemValid.
  - On MemValid: write MemData into data[index][counter].
  - If counter < WORDS-1: increment counter and advance MemAddr by 4.
  - If counter = WORDS-1: MemReq=0, valid[index]=1, tag stored; go to FILL_DONE.
  - MemValid while MemReq=0 is ignored.
- FILL_DONE:
  - One cycle, stall still 1; go to IDLE.
  - Gives a registered-array read before the hit is reported.
- Refill latency on a miss is WORDS memory beats plus 2 cycles; the PC advances on the first hit edge.
- The refilled line is the one latched at miss time. A ProgAddr change during refill is harmless: the new address is re-evaluated in IDLE.
- Flush during REFILL/FILL_DONE:
  - Recorded as pending; the refill finishes and its memory beats are consumed.
  - On return to IDLE, all valid bits are cleared, including the new line.
- Reset mid-refill: abort immediately, MemReq=0, all lines invalid. The memory side must discard an in-flight beat.
- Index wrap: the line at index LINES-1 is followed by index 0 of the next tag; no special case.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined: extra output ports HitCount and MissCount, each 32 bits, both reset to 0.
  - HitCount increments on every cycle with a hit (IDLE, hit).
  - MissCount increments on each IDLE to REFILL transition.
  - Both saturate at 32'hFFFFFFFF.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, ProgAddr=0x00000000, memory returns 0xA0,0xA1,0xA2,0xA3 with MemValid every cycle -> MemAddr 0x0,0x4,0x8,0xC; stall for 6 cycles; then Instruction=0xA0 with stall=0.
- Sequential hits: after the cold miss, ProgAddr=0x4, then 0x8, then 0xC -> Instruction 0xA1, 0xA2, 0xA3, stall=0 every cycle, MemReq=0.
- Conflict miss: after line 0 is filled, ProgAddr=0x100 (LINES=16, WORDS=4, same index, new tag) -> refill from 0x100; return to 0x0 -> miss again.
- Slow memory: MemValid asserted only every 3rd cycle -> MemAddr held stable between beats; stall lasts 4x3+2 cycles; correct data is stored.
- Flush mid-refill: Flush pulsed during the second beat -> all 4 beats consumed; after FILL_DONE the line is invalid and the same ProgAddr misses again.
- Reset mid-refill: reset=0 after 2 beats -> MemReq=0 next edge; address 0x0 misses after reset release. With ICACHE_STATS_EN, HitCount=MissCount=0.
